layer_mixer: RTL and testbench

//  Final pixel stage between the layer engines (background_engine, tank/bullet sprite engines)
//  and the VGA pins. Delay-matches sync/video_on and sprite layers to the background pipeline,

---
 rtl/layer_mixer.sv | 165 ++++++++++++++++
 tb/tb_layer_mixer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mixer.sv
// layer_mixer
//   Last pixel stage before the VGA pins. Video timing (video_on/hsync/vsync)
//   and the sprite layers are delayed so they line up with the slower
//   background pipeline. One 12-bit colour per pixel is then chosen by fixed
//   priority and registered together with the sync outputs. Sticky per-frame
//   overlap flags are kept for the game logic and published at frame end.
//
//   Handshake: none. Every input is sampled once per pixel clock, and every
//   output is a plain registered level, except frame_done, which is a
//   one-cycle strobe qualifying the hit_* and frame_count update.
//
// Ports
//   clk, reset                         pixel clock, synchronous active-high reset
//   video_on, hsync, vsync             timing from the sync generator (sync active low)
//   bg_on, bg_color                    background layer, BG_LAT cycles after timing
//   tank0_on/color, tank1_on/color,
//   bullet_on/color                    sprite layers, SPR_LAT cycles after timing
//   rgb, hsync_o, vsync_o              registered pixel and sync, mutually aligned
//   hit_t0_b, hit_t1_b, hit_t0_t1      overlap flags of the last completed frame
//   frame_done                         one-cycle strobe when the hit_* flags update
//   frame_count                        completed frames since reset (wraps)
module layer_mixer #(
   parameter int          BG_LAT      = 2,
   parameter int          SPR_LAT     = 1,
   parameter logic [11:0] BLANK_COLOR = 12'h000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        video_on,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        bg_on,
   input  logic [11:0] bg_color,
   input  logic        tank0_on,
   input  logic [11:0] tank0_color,
   input  logic        tank1_on,
   input  logic [11:0] tank1_color,
   input  logic        bullet_on,
   input  logic [11:0] bullet_color,
   output logic [11:0] rgb,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        hit_t0_b,
   output logic        hit_t1_b,
   output logic        hit_t0_t1,
   output logic        frame_done,
   output logic [15:0] frame_count
);

   localparam int SPR_DLY = BG_LAT - SPR_LAT;
   localparam int SPR_W   = 39;
   // Idle value of the timing pipe {video_on, hsync, vsync}: blanked, sync inactive.
   localparam logic [2:0] SYNC_IDLE = 3'b011;

   generate
      if (SPR_LAT < 0 || BG_LAT < SPR_LAT) begin : g_bad_lat
         $error("layer_mixer: latencies must satisfy BG_LAT >= SPR_LAT >= 0");
      end
   endgenerate

   // ---------------- stage A: alignment delays ----------------
   logic [2:0]       sync_in, sync_d;
   logic [SPR_W-1:0] spr_in, spr_d;

   assign sync_in = {video_on, hsync, vsync};
   assign spr_in  = {tank0_on, tank0_color, tank1_on, tank1_color, bullet_on, bullet_color};

   generate
      if (BG_LAT == 0) begin : g_sync_pass
         assign sync_d = sync_in;
      end else begin : g_sync_dly
         logic [2:0] sr [BG_LAT];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < BG_LAT; i++) sr[i] <= SYNC_IDLE;
            end else begin
               sr[0] <= sync_in;
               for (int i = 1; i < BG_LAT; i++) sr[i] <= sr[i-1];
            end
         end
         assign sync_d = sr[BG_LAT-1];
      end

      if (SPR_DLY == 0) begin : g_spr_pass
         assign spr_d = spr_in;
      end else begin : g_spr_dly
         logic [SPR_W-1:0] sr [SPR_DLY];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < SPR_DLY; i++) sr[i] <= '0;
            end else begin
               sr[0] <= spr_in;
               for (int i = 1; i < SPR_DLY; i++) sr[i] <= sr[i-1];
            end
         end
         assign spr_d = sr[SPR_DLY-1];
      end
   endgenerate

   logic        vid_d, hs_d, vs_d;
   logic        t0_on_d, t1_on_d, b_on_d;
   logic [11:0] t0_c_d, t1_c_d, b_c_d;

   assign {vid_d, hs_d, vs_d} = sync_d;
   assign {t0_on_d, t0_c_d, t1_on_d, t1_c_d, b_on_d, b_c_d} = spr_d;

   // ---------------- stage B: priority select and output register ----------------
   logic [11:0] pix;

   always_comb begin
      pix = BLANK_COLOR;
      if (vid_d) begin
         if (b_on_d)       pix = b_c_d;
         else if (t0_on_d) pix = t0_c_d;
         else if (t1_on_d) pix = t1_c_d;
         else if (bg_on)   pix = bg_color;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rgb     <= BLANK_COLOR;
         hsync_o <= 1'b1;
         vsync_o <= 1'b1;
      end else begin
         rgb     <= pix;
         hsync_o <= hs_d;
         vsync_o <= vs_d;
      end
   end

   // ---------------- per-frame overlap tracking ----------------
   logic       vs_prev;
   logic       frame_end;
   logic [2:0] acc;       // {t0&b, t1&b, t0&t1}, sticky within a frame
   logic [2:0] overlap;

   // Frame end is the 1->0 edge of the aligned vsync, so it lines up with vsync_o.
   assign frame_end = vs_prev & ~vs_d;
   assign overlap   = {t0_on_d & b_on_d, t1_on_d & b_on_d, t0_on_d & t1_on_d} & {3{vid_d}};

   always_ff @(posedge clk) begin
      if (reset) begin
         vs_prev     <= 1'b1;
         acc         <= '0;
         hit_t0_b    <= 1'b0;
         hit_t1_b    <= 1'b0;
         hit_t0_t1   <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
      end else begin
         vs_prev    <= vs_d;
         frame_done <= frame_end;
         if (frame_end) begin
            // Clearing wins over any overlap seen on this same cycle.
            {hit_t0_b, hit_t1_b, hit_t0_t1} <= acc;
            acc         <= '0;
            frame_count <= frame_count + 16'd1;
         end else begin
            acc <= acc | overlap;
         end
      end
   end

endmodule

// File: tb/tb_layer_mixer.sv
// Testbench for layer_mixer (BG_LAT=2, SPR_LAT=1, BLANK_COLOR=000).
// Table of steady-state priority/blanking vectors plus hand-written
// sequences for latency, frame-end hit reporting, counter wrap and reset.
module tb_layer_mixer;

   logic        clk = 1'b0;
   logic        reset;
   logic        video_on, hsync, vsync;
   logic        bg_on, tank0_on, tank1_on, bullet_on;
   logic [11:0] bg_color, tank0_color, tank1_color, bullet_color;
   logic [11:0] rgb;
   logic        hsync_o, vsync_o;
   logic        hit_t0_b, hit_t1_b, hit_t0_t1, frame_done;
   logic [15:0] frame_count;

   int checks   = 0;
   int failures = 0;

   layer_mixer #(.BG_LAT(2), .SPR_LAT(1), .BLANK_COLOR(12'h000)) dut (
      .clk(clk), .reset(reset),
      .video_on(video_on), .hsync(hsync), .vsync(vsync),
      .bg_on(bg_on), .bg_color(bg_color),
      .tank0_on(tank0_on), .tank0_color(tank0_color),
      .tank1_on(tank1_on), .tank1_color(tank1_color),
      .bullet_on(bullet_on), .bullet_color(bullet_color),
      .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o),
      .hit_t0_b(hit_t0_b), .hit_t1_b(hit_t1_b), .hit_t0_t1(hit_t0_t1),
      .frame_done(frame_done), .frame_count(frame_count)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      video_on = 1'b0; hsync = 1'b1; vsync = 1'b1;
      bg_on = 1'b0; bg_color = 12'h000;
      tank0_on = 1'b0; tank1_on = 1'b0; bullet_on = 1'b0;
      tank0_color = 12'h333; tank1_color = 12'h222; bullet_color = 12'h444;
   endtask

   // Drives one pixel of timing plus sprite flags in the same cycle, then steps.
   task automatic drive(input logic vid, input logic t0, input logic t1, input logic b);
      video_on = vid; tank0_on = t0; tank1_on = t1; bullet_on = b;
      step();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // vsync falls with video off; the outputs must report the frame 3 cycles later.
   task automatic frame_end(input logic e_t0b, input logic e_t1b, input logic e_t0t1,
                            input logic [15:0] e_cnt);
      idle();
      vsync = 1'b0;
      step();
      step();
      check("frame_done_early", frame_done, 1'b0);
      step();
      check("frame_done_pulse", frame_done, 1'b1);
      check("vsync_o_low", vsync_o, 1'b0);
      check("hit_t0_b", hit_t0_b, e_t0b);
      check("hit_t1_b", hit_t1_b, e_t1b);
      check("hit_t0_t1", hit_t0_t1, e_t0t1);
      check("frame_count", frame_count, e_cnt);
      step();
      check("frame_done_width", frame_done, 1'b0);
      vsync = 1'b1;
      repeat (3) step();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        vid;
      logic        hs;
      logic        bg_on;
      logic [11:0] bg_c;
      logic        t0_on;
      logic        t1_on;
      logic        b_on;
      logic [11:0] b_c;
      logic [11:0] exp_rgb;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(input logic vid, input logic hs, input logic bgo,
                               input logic [11:0] bgc, input logic t0, input logic t1,
                               input logic b, input logic [11:0] bc, input logic [11:0] e);
      vec_t v;
      v.vid = vid; v.hs = hs; v.bg_on = bgo; v.bg_c = bgc;
      v.t0_on = t0; v.t1_on = t1; v.b_on = b; v.b_c = bc; v.exp_rgb = e;
      return v;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [11:0] exp_q[$];
      logic [11:0] exp_rgb;

      idle();
      reset = 1'b1;
      repeat (3) step();
      check("rst_rgb", rgb, 12'h000);
      check("rst_hsync_o", hsync_o, 1'b1);
      check("rst_vsync_o", vsync_o, 1'b1);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_frame_count", frame_count, 16'h0000);
      check("rst_hits", {hit_t0_b, hit_t1_b, hit_t0_t1}, 3'b000);
      reset = 1'b0;
      step();

      // Tank colours: t0=333, t1=222 (set by idle()).
      vecs[0] = mk(1, 0, 1, 12'h111, 1, 1, 1, 12'h444, 12'h444);
      vecs[1] = mk(1, 1, 1, 12'h111, 1, 1, 0, 12'h444, 12'h333);
      vecs[2] = mk(1, 0, 1, 12'h111, 0, 1, 0, 12'h444, 12'h222);
      vecs[3] = mk(1, 1, 1, 12'h111, 0, 0, 0, 12'h444, 12'h111);
      vecs[4] = mk(1, 0, 0, 12'h111, 0, 0, 0, 12'h444, 12'h000);
      vecs[5] = mk(0, 1, 1, 12'hFFF, 0, 0, 0, 12'h444, 12'h000);
      vecs[6] = mk(0, 0, 1, 12'hFFF, 1, 1, 1, 12'h444, 12'h000);
      vecs[7] = mk(1, 1, 1, 12'h7E7, 0, 1, 1, 12'h0F0, 12'h0F0);

      foreach (vecs[i]) exp_q.push_back(vecs[i].exp_rgb);
      foreach (vecs[i]) begin
         video_on = vecs[i].vid; hsync = vecs[i].hs;
         bg_on = vecs[i].bg_on; bg_color = vecs[i].bg_c;
         tank0_on = vecs[i].t0_on; tank1_on = vecs[i].t1_on;
         bullet_on = vecs[i].b_on; bullet_color = vecs[i].b_c;
         repeat (4) step();
         exp_rgb = exp_q.pop_front();
         check($sformatf("vec%0d_rgb", i), rgb, exp_rgb);
         check($sformatf("vec%0d_hsync_o", i), hsync_o, vecs[i].hs);
         check($sformatf("vec%0d_vsync_o", i), vsync_o, 1'b1);
      end
      idle();
      repeat (4) step();

      // Background latency: timing at t, bg at t+2, rgb/hsync_o at t+3.
      video_on = 1'b1; hsync = 1'b0;
      step();
      video_on = 1'b0; hsync = 1'b1;
      step();
      bg_on = 1'b1; bg_color = 12'hABC;
      check("lat_rgb_t2", rgb, 12'h000);
      check("lat_hsync_t2", hsync_o, 1'b1);
      step();
      bg_on = 1'b0; bg_color = 12'h000;
      check("lat_rgb_t3", rgb, 12'hABC);
      check("lat_hsync_t3", hsync_o, 1'b0);
      step();
      check("lat_rgb_t4", rgb, 12'h000);
      check("lat_hsync_t4", hsync_o, 1'b1);

      // Sprite latency: timing at t, bullet at t+1, bg at t+2 -> bullet wins at t+3.
      repeat (2) step();
      video_on = 1'b1;
      step();
      video_on = 1'b0; bullet_on = 1'b1; bullet_color = 12'h00F;
      step();
      bullet_on = 1'b0; bg_on = 1'b1; bg_color = 12'h123;
      step();
      idle();
      check("spr_lat_rgb", rgb, 12'h00F);
      repeat (3) step();

      // The table's visible all-on vectors left every overlap flag set.
      frame_end(1, 1, 1, 16'd1);

      // Frame with a single tank0/bullet overlap pixel inside the visible area.
      drive(1, 0, 0, 0);
      drive(1, 1, 0, 1);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      repeat (3) drive(0, 0, 0, 0);
      frame_end(1, 0, 0, 16'd2);

      // Clean frame.
      repeat (3) drive(1, 0, 0, 0);
      repeat (3) drive(0, 0, 0, 0);
      frame_end(0, 0, 0, 16'd3);

      // Overlaps only while blanked do not count.
      repeat (3) drive(0, 1, 1, 1);
      repeat (3) drive(0, 0, 0, 0);
      frame_end(0, 0, 0, 16'd4);

      // Counter wrap.
      force dut.frame_count = 16'hFFFF;
      step();
      release dut.frame_count;
      step();
      check("wrap_preload", frame_count, 16'hFFFF);
      frame_end(0, 0, 0, 16'd0);

      // Tank0/tank1 overlap frame so the outputs are non-zero before reset.
      drive(1, 0, 0, 0);
      drive(1, 1, 1, 0);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      repeat (3) drive(0, 0, 0, 0);
      frame_end(0, 0, 1, 16'd1);

      // Mid-frame reset after an overlap, with a visible background pixel in flight.
      bg_on = 1'b1; bg_color = 12'h5A5;
      drive(1, 0, 0, 0);
      drive(1, 1, 0, 1);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      check("pre_reset_rgb", rgb, 12'h5A5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle();
      check("mid_rst_rgb", rgb, 12'h000);
      check("mid_rst_hsync_o", hsync_o, 1'b1);
      check("mid_rst_vsync_o", vsync_o, 1'b1);
      check("mid_rst_frame_done", frame_done, 1'b0);
      check("mid_rst_hits", {hit_t0_b, hit_t1_b, hit_t0_t1}, 3'b000);
      check("mid_rst_frame_count", frame_count, 16'h0000);
      repeat (3) step();
      frame_end(0, 0, 0, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
